// File: rtl/arm_serial_pkg.sv
// Shared widths, frame length and FSM state encoding for the serial frame transmitter.
package arm_serial_pkg;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int FRAME_LEN = 1 + AW + 1 + DW + 1 + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    GAP_A,
    DATA,
    GAP_D,
    STOP
  } tx_state_t;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, shift-left register exposing its MSB as the serial output bit.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] parIn,
  output logic             msb
);

  logic [WIDTH-1:0] shiftReg;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      shiftReg <= '0;
    end else if (load) begin
      shiftReg <= parIn;
    end else if (shift) begin
      shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shiftReg[WIDTH-1];

endmodule

// File: rtl/arm_serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start 0, address, Z gap, data, Z gap, stop 0,
// one bit per clk_in, with a strobe OutC that rises mid-bit while a frame is in flight.
module arm_serial_frame_tx #(
  parameter int AW = arm_serial_pkg::AW,
  parameter int DW = arm_serial_pkg::DW
) (
  input  logic          clk_in,
  input  logic          reset,
  output logic          OutD,
  output logic          OutC,
  input  logic [DW-1:0] D,
  input  logic [AW-1:0] A,
  input  logic          Go
);

  import arm_serial_pkg::*;

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);

  tx_state_t     state;
  tx_state_t     nextState;
  logic [CW-1:0] bitCnt;
  logic          busy;
  logic          holdHigh;
  logic          loadEn;
  logic          addrShift;
  logic          dataShift;
  logic          addrMsb;
  logic          dataMsb;
  logic          outDVal;
  logic          outDEn;
  logic          lastAddrBit;
  logic          lastDataBit;

  assign lastAddrBit = (bitCnt == ADDR_LAST);
  assign lastDataBit = (bitCnt == DATA_LAST);

  piso_shift #(.WIDTH(AW)) addrShifter (
    .clk_in (clk_in),
    .reset  (reset),
    .load   (loadEn),
    .shift  (addrShift),
    .parIn  (A),
    .msb    (addrMsb)
  );

  piso_shift #(.WIDTH(DW)) dataShifter (
    .clk_in (clk_in),
    .reset  (reset),
    .load   (loadEn),
    .shift  (dataShift),
    .parIn  (D),
    .msb    (dataMsb)
  );

  // busy is registered from the next state so it changes cleanly at the same edge as state
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= nextState;
      busy  <= (nextState != IDLE);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      bitCnt <= '0;
    end else if ((state == ADDR && !lastAddrBit) || (state == DATA && !lastDataBit)) begin
      bitCnt <= bitCnt + 1'b1;
    end else begin
      bitCnt <= '0;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (Go) nextState = START;
      START:   nextState = ADDR;
      ADDR:    if (lastAddrBit) nextState = GAP_A;
      GAP_A:   nextState = DATA;
      DATA:    if (lastDataBit) nextState = GAP_D;
      GAP_D:   nextState = STOP;
      STOP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    outDVal   = 1'b1;
    outDEn    = 1'b1;
    loadEn    = 1'b0;
    addrShift = 1'b0;
    dataShift = 1'b0;
    unique case (state)
      IDLE: begin
        outDVal = 1'b1;
        loadEn  = Go;
      end
      START: outDVal = 1'b0;
      ADDR: begin
        outDVal   = addrMsb;
        addrShift = 1'b1;
      end
      GAP_A: outDEn = 1'b0;
      DATA: begin
        outDVal   = dataMsb;
        dataShift = 1'b1;
      end
      GAP_D: outDEn = 1'b0;
      STOP:  outDVal = 1'b0;
      default: begin
        outDVal = 1'b1;
        outDEn  = 1'b1;
      end
    endcase
  end

  assign OutD = outDEn ? outDVal : 1'bz;

  // Captured mid-bit so OutC stays high across the edge where busy drops (end of frame or
  // reset), avoiding a runt low pulse that the receiver would see as an extra strobe.
  always_ff @(negedge clk_in) begin
    holdHigh <= reset || (state == STOP);
  end

  assign OutC = ~clk_in | ~busy | holdHigh;

endmodule

// File: tb/tb_arm_serial_frame_tx.sv
// Bench for arm_serial_frame_tx: frame-level reference model plus a strobe-driven receiver.
module tb_arm_serial_frame_tx;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       Go;
  logic [6:0] A;
  logic [7:0] D;
  wire        OutD;
  wire        OutC;

  int checks   = 0;
  int failures = 0;
  bit chkEn    = 1'b0;

  // reference model state
  bit         mBusy = 1'b0;
  int         mPos  = 0;
  logic [6:0] mA    = '0;
  logic [7:0] mD    = '0;

  // receiver
  int rx[$];
  int riseCnt = 0;

  arm_serial_frame_tx dut (
    .clk_in (clk_in),
    .reset  (reset),
    .OutD   (OutD),
    .OutC   (OutC),
    .D      (D),
    .A      (A),
    .Go     (Go)
  );

  always #5 clk_in = ~clk_in;

  // symbols: 0, 1, 2 = high-Z, 3 = unknown
  function automatic int frameSym(int pos, logic [6:0] a, logic [7:0] d);
    if (pos == 0) return 0;
    if (pos <= 7) return int'(a[7 - pos]);
    if (pos == 8) return 2;
    if (pos <= 16) return int'(d[16 - pos]);
    if (pos == 17) return 2;
    return 0;
  endfunction

  function automatic int dutSym();
    if (OutD === 1'bz || !dut.outDEn) return 2;
    if (OutD === 1'b1) return 1;
    if (OutD === 1'b0) return 0;
    return 3;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_in) begin
    if (reset) begin
      mBusy <= 1'b0;
    end else if (mBusy) begin
      if (mPos == 18) mBusy <= 1'b0;
      else mPos <= mPos + 1;
    end else if (Go) begin
      mBusy <= 1'b1;
      mPos  <= 0;
      mA    <= A;
      mD    <= D;
    end
  end

  always begin
    @(posedge clk_in);
    #2;
    if (chkEn) chk("outc_high_phase", int'(OutC), mBusy ? 0 : 1);
    @(negedge clk_in);
    if (chkEn) begin
      chk("outd_symbol", dutSym(), mBusy ? frameSym(mPos, mA, mD) : 1);
      chk("outc_low_phase", int'(OutC), 1);
    end
  end

  always @(posedge OutC) begin
    riseCnt++;
    rx.push_back(dutSym());
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic rxClear();
    rx.delete();
    riseCnt = 0;
  endtask

  task automatic checkFrame(string tag, int off, logic [6:0] ea, logic [7:0] ed);
    logic [6:0] ra;
    logic [7:0] rd;
    bit         ok;
    if (rx.size() < off + 19) begin
      chk({tag, "_length"}, rx.size(), off + 19);
      return;
    end
    ok = (rx[off] == 0) && (rx[off + 8] == 2) && (rx[off + 17] == 2) && (rx[off + 18] == 0);
    ra = '0;
    rd = '0;
    for (int i = 0; i < 7; i++) begin
      if (rx[off + 1 + i] > 1) ok = 1'b0;
      ra = {ra[5:0], rx[off + 1 + i][0]};
    end
    for (int i = 0; i < 8; i++) begin
      if (rx[off + 9 + i] > 1) ok = 1'b0;
      rd = {rd[6:0], rx[off + 9 + i][0]};
    end
    chk({tag, "_framing"}, int'(ok), 1);
    chk({tag, "_addr"}, int'(ra), int'(ea));
    chk({tag, "_data"}, int'(rd), int'(ed));
  endtask

  task automatic sendFrame(logic [6:0] a, logic [7:0] d);
    A  = a;
    D  = d;
    Go = 1'b1;
    tick(1);
    Go = 1'b0;
    tick(20);
  endtask

  initial begin
    reset = 1'b1;
    Go    = 1'b0;
    A     = '0;
    D     = '0;
    tick(1);
    chkEn = 1'b1;
    tick(1);
    chk("reset_outd", dutSym(), 1);
    chk("reset_outc", int'(OutC), 1);
    reset = 1'b0;

    // idle with Go low
    rxClear();
    tick(10);
    chk("idle_rises", riseCnt, 0);

    // sparse pattern
    rxClear();
    sendFrame(7'b1000001, 8'b10000001);
    chk("f1_rises", riseCnt, 19);
    checkFrame("f1", 0, 7'h41, 8'h81);

    // all ones
    rxClear();
    sendFrame(7'b1111111, 8'hFF);
    chk("f2_rises", riseCnt, 19);
    checkFrame("f2", 0, 7'h7F, 8'hFF);

    // disturb A/D and Go mid-frame
    rxClear();
    A  = 7'b1000001;
    D  = 8'b10011111;
    Go = 1'b1;
    tick(1);
    Go = 1'b0;
    tick(9);
    A  = 7'h2A;
    D  = 8'h55;
    Go = 1'b1;
    tick(1);
    Go = 1'b0;
    tick(15);
    chk("f3_rises", riseCnt, 19);
    checkFrame("f3", 0, 7'h41, 8'h9F);

    // reset during DATA bit 3
    rxClear();
    A  = 7'h35;
    D  = 8'hC3;
    Go = 1'b1;
    tick(1);
    Go = 1'b0;
    tick(12);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_rises", riseCnt, 13);
    chk("abort_outd", dutSym(), 1);
    chk("abort_outc", int'(OutC), 1);
    rxClear();
    tick(10);
    chk("abort_idle_rises", riseCnt, 0);
    rxClear();
    sendFrame(7'h12, 8'h34);
    checkFrame("f4", 0, 7'h12, 8'h34);

    // Go held high for 45 cycles
    rxClear();
    A  = 7'h55;
    D  = 8'hA5;
    Go = 1'b1;
    tick(5);
    A  = 7'h2B;
    D  = 8'h5A;
    tick(40);
    Go = 1'b0;
    tick(20);
    chk("held_rises", riseCnt, 57);
    checkFrame("held_a", 0, 7'h55, 8'hA5);
    checkFrame("held_b", 19, 7'h2B, 8'h5A);
    checkFrame("held_c", 38, 7'h2B, 8'h5A);

    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
